// File: rtl/optical_byte_rx_pkg.sv
// ---------------------------------------------------------------------------
// optical_pkg
//   Types and constants shared by both ends of the optical audio link; the
//   transmitter on the other FPGA imports the same package.
//   - rx_state_e           : receiver FSM states
//   - DEFAULT_CLKS_PER_BIT : 25 MHz clock / 1 Mbit/s line rate
//   - IDLE_LEVEL           : level the line rests at between frames
//   - even_parity_ok()     : true when data plus parity bit has even weight
// ---------------------------------------------------------------------------
package optical_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4,
    BREAK  = 3'd5
  } rx_state_e;

  localparam int   DEFAULT_CLKS_PER_BIT = 25;
  localparam logic IDLE_LEVEL           = 1'b1;

  function automatic logic even_parity_ok(input logic [7:0] data, input logic par);
    return (^{data, par}) == 1'b0;
  endfunction

endpackage

// File: rtl/optical_byte_rx_if.sv
// ---------------------------------------------------------------------------
// optical_byte_rx_if
//   Line input and byte/status outputs of the optical byte receiver.
//   Parameter COUNT_W : width of byte_count_out.
//   Signals:
//     rx_in           raw optical line (idle high, asynchronous)
//     data_out[7:0]   last good byte
//     valid_out       one-cycle strobe, data_out is new
//     framing_err_out one-cycle strobe, stop bit sampled low
//     parity_err_out  one-cycle strobe, parity mismatch
//     byte_count_out  saturating count of good bytes
//     busy_out        receiver is not idle
//   Modports: master = receiver, slave = line driver / byte consumer.
// ---------------------------------------------------------------------------
interface optical_byte_rx_if #(
  parameter int COUNT_W = 16
);
  logic               rx_in;
  logic [7:0]         data_out;
  logic               valid_out;
  logic               framing_err_out;
  logic               parity_err_out;
  logic [COUNT_W-1:0] byte_count_out;
  logic               busy_out;

  modport master (
    input  rx_in,
    output data_out, valid_out, framing_err_out, parity_err_out,
           byte_count_out, busy_out
  );

  modport slave (
    output rx_in,
    input  data_out, valid_out, framing_err_out, parity_err_out,
           byte_count_out, busy_out
  );
endinterface

// File: rtl/optical_byte_rx_sync_2ff.sv
// ---------------------------------------------------------------------------
// sync_2ff
//   1-bit two-flop synchronizer for the asynchronous photodiode line.
//   Both flops preset to the idle line level while reset is asserted, so a
//   reset never looks like a falling start edge.
//   Ports:
//     clk_in   : destination clock
//     rst_n_in : asynchronous active-low reset (presets flops to 1)
//     d_in     : asynchronous input
//     q_out    : synchronized output, 2 cycles of latency
// ---------------------------------------------------------------------------
module sync_2ff
  import optical_pkg::*;
(
  input  logic clk_in,
  input  logic rst_n_in,
  input  logic d_in,
  output logic q_out
);

  logic [1:0] stage_reg;

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      stage_reg <= {2{IDLE_LEVEL}};
    end else begin
      stage_reg <= {stage_reg[0], d_in};
    end
  end

  assign q_out = stage_reg[1];

endmodule

// File: rtl/optical_byte_rx.sv
// ---------------------------------------------------------------------------
// optical_byte_rx
//   Receive end of the optical audio link. Recovers 8-bit asynchronous
//   serial frames (start, d0..d7 LSB first, [parity], stop) from the
//   photodiode line, presents each good byte with a one-cycle valid strobe
//   and keeps a saturating count of good bytes for the debug display.
//
//   Parameters:
//     CLKS_PER_BIT : clock cycles per serial bit (>= 4)
//     COUNT_W      : width of the good-byte counter
//   Ports:
//     clk_in   : system clock
//     rst_n_in : asynchronous active-low reset
//     bus      : optical_byte_rx_if.master (rx_in in; data/strobes/count/busy out)
//
//   Build option:
//     OPTICAL_RX_PARITY_EN - frames carry an even-parity bit after d7 and
//                            parity_err_out is live; otherwise there is no
//                            parity bit and parity_err_out is tied low.
// ---------------------------------------------------------------------------
module optical_byte_rx
  import optical_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int COUNT_W      = 16
) (
  input  logic                clk_in,
  input  logic                rst_n_in,
  optical_byte_rx_if.master   bus
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0]   HALF_CNT  = CNT_W'(CLKS_PER_BIT / 2);
  localparam logic [CNT_W-1:0]   LAST_CNT  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [COUNT_W-1:0] COUNT_MAX = {COUNT_W{1'b1}};

  logic rx_s;

  sync_2ff u_sync (
    .clk_in   (clk_in),
    .rst_n_in (rst_n_in),
    .d_in     (bus.rx_in),
    .q_out    (rx_s)
  );

  rx_state_e          state_reg,   state_next;
  logic [CNT_W-1:0]   cnt_reg,     cnt_next;
  logic [7:0]         shift_reg,   shift_next;
  logic [2:0]         bit_idx_reg, bit_idx_next;
  logic [7:0]         data_reg,    data_next;
  logic [COUNT_W-1:0] count_reg,   count_next;
  logic               valid_reg,   valid_next;
  logic               ferr_reg,    ferr_next;
  logic               parity_ok;
`ifdef OPTICAL_RX_PARITY_EN
  logic               par_reg,     par_next;
  logic               perr_reg,    perr_next;

  assign parity_ok = even_parity_ok(shift_reg, par_reg);
`else
  assign parity_ok = 1'b1;
`endif

  // State register. Reset parks the FSM in BREAK so it only enters IDLE
  // once the synchronized line has been seen high.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_reg   <= BREAK;
      cnt_reg     <= '0;
      shift_reg   <= '0;
      bit_idx_reg <= '0;
      data_reg    <= '0;
      count_reg   <= '0;
      valid_reg   <= 1'b0;
      ferr_reg    <= 1'b0;
`ifdef OPTICAL_RX_PARITY_EN
      par_reg     <= 1'b0;
      perr_reg    <= 1'b0;
`endif
    end else begin
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      shift_reg   <= shift_next;
      bit_idx_reg <= bit_idx_next;
      data_reg    <= data_next;
      count_reg   <= count_next;
      valid_reg   <= valid_next;
      ferr_reg    <= ferr_next;
`ifdef OPTICAL_RX_PARITY_EN
      par_reg     <= par_next;
      perr_reg    <= perr_next;
`endif
    end
  end

  // Next-state and output logic. The bit-period counter free-runs by default
  // and is cleared at every sample point, so each sample lands exactly one
  // bit period after the previous one.
  always_comb begin
    state_next   = state_reg;
    cnt_next     = cnt_reg + 1'b1;
    shift_next   = shift_reg;
    bit_idx_next = bit_idx_reg;
    data_next    = data_reg;
    count_next   = count_reg;
    valid_next   = 1'b0;
    ferr_next    = 1'b0;
`ifdef OPTICAL_RX_PARITY_EN
    par_next     = par_reg;
    perr_next    = 1'b0;
`endif

    case (state_reg)
      IDLE: begin
        cnt_next = '0;
        if (rx_s != IDLE_LEVEL) begin
          state_next = START;
        end
      end

      START: begin
        // Mid-start-bit check rejects short low glitches.
        if (cnt_reg == HALF_CNT) begin
          cnt_next = '0;
          if (rx_s == IDLE_LEVEL) begin
            state_next = IDLE;
          end else begin
            state_next   = DATA;
            bit_idx_next = '0;
          end
        end
      end

      DATA: begin
        if (cnt_reg == LAST_CNT) begin
          cnt_next     = '0;
          // LSB arrives first, so shifting in at the MSB leaves d0 at bit 0.
          shift_next   = {rx_s, shift_reg[7:1]};
          bit_idx_next = bit_idx_reg + 1'b1;
          if (bit_idx_reg == 3'd7) begin
`ifdef OPTICAL_RX_PARITY_EN
            state_next = PARITY;
`else
            state_next = STOP;
`endif
          end
        end
      end

`ifdef OPTICAL_RX_PARITY_EN
      PARITY: begin
        if (cnt_reg == LAST_CNT) begin
          cnt_next   = '0;
          par_next   = rx_s;
          state_next = STOP;
        end
      end
`endif

      STOP: begin
        if (cnt_reg == LAST_CNT) begin
          cnt_next = '0;
          if (rx_s != IDLE_LEVEL) begin
            // Framing error wins over parity; BREAK stops a stuck-low line
            // from being decoded as an endless run of zero frames.
            ferr_next  = 1'b1;
            state_next = BREAK;
          end else if (!parity_ok) begin
`ifdef OPTICAL_RX_PARITY_EN
            perr_next  = 1'b1;
`endif
            state_next = IDLE;
          end else begin
            data_next  = shift_reg;
            valid_next = 1'b1;
            if (count_reg != COUNT_MAX) begin
              count_next = count_reg + 1'b1;
            end
            state_next = IDLE;
          end
        end
      end

      BREAK: begin
        cnt_next = '0;
        if (rx_s == IDLE_LEVEL) begin
          state_next = IDLE;
        end
      end

      default: begin
        state_next = BREAK;
      end
    endcase
  end

  assign bus.data_out        = data_reg;
  assign bus.valid_out       = valid_reg;
  assign bus.framing_err_out = ferr_reg;
  assign bus.byte_count_out  = count_reg;
  assign bus.busy_out        = (state_reg != IDLE);
`ifdef OPTICAL_RX_PARITY_EN
  assign bus.parity_err_out  = perr_reg;
`else
  assign bus.parity_err_out  = 1'b0;
`endif

endmodule

// File: tb/tb_optical_byte_rx.sv
// ---------------------------------------------------------------------------
// tb_optical_byte_rx
//   Drives serial frames onto the optical line and compares the recovered
//   bytes, strobes and counters with a frame-level reference model.
//   Two receivers share the line: one with a 16-bit counter and one with a
//   2-bit counter to exercise saturation.
// ---------------------------------------------------------------------------
module tb_optical_byte_rx;
  import optical_pkg::*;

  localparam int CPB = 8;
`ifdef OPTICAL_RX_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  logic clk     = 1'b0;
  logic rst_n   = 1'b0;
  logic rx_line = 1'b1;

  always #5 clk = ~clk;

  optical_byte_rx_if #(.COUNT_W(16)) bus0 ();
  optical_byte_rx_if #(.COUNT_W(2))  bus1 ();

  assign bus0.rx_in = rx_line;
  assign bus1.rx_in = rx_line;

  optical_byte_rx #(.CLKS_PER_BIT(CPB), .COUNT_W(16)) dut (
    .clk_in   (clk),
    .rst_n_in (rst_n),
    .bus      (bus0)
  );

  optical_byte_rx #(.CLKS_PER_BIT(CPB), .COUNT_W(2)) dut_sat (
    .clk_in   (clk),
    .rst_n_in (rst_n),
    .bus      (bus1)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Observed strobes, collected on the falling edge.
  logic [7:0] got_q[$];
  int got_ferr  = 0;
  int got_perr  = 0;
  int excl_viol = 0;

  always @(negedge clk) begin
    if (bus0.valid_out === 1'b1) got_q.push_back(bus0.data_out);
    if (bus0.framing_err_out === 1'b1) got_ferr++;
    if (bus0.parity_err_out === 1'b1) got_perr++;
    if ((32'(bus0.valid_out) + 32'(bus0.framing_err_out) + 32'(bus0.parity_err_out)) > 1)
      excl_viol++;
  end

  // Frame-level reference model.
  logic [7:0] exp_q[$];
  int         exp_ferr   = 0;
  int         exp_perr   = 0;
  logic [7:0] model_data = 8'h00;
  int         model_good = 0;

  task automatic model_frame(input logic [7:0] d, input logic p, input logic stop);
    if (!stop) begin
      exp_ferr++;
    end else if (PAR_EN && (($countones(d) + int'(p)) % 2 != 0)) begin
      exp_perr++;
    end else begin
      exp_q.push_back(d);
      model_data = d;
      model_good++;
    end
  endtask

  task automatic clear_logs();
    got_q.delete();
    exp_q.delete();
    got_ferr = 0; got_perr = 0;
    exp_ferr = 0; exp_perr = 0;
  endtask

  // Line driving: called just after a rising edge, returns just after one.
  task automatic send_bit(input logic b, input int n);
    rx_line = b;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic p, input logic stop, input int stop_len);
    send_bit(1'b0, CPB);
    for (int i = 0; i < 8; i++) send_bit(d[i], CPB);
    if (PAR_EN) send_bit(p, CPB);
    send_bit(stop, stop_len);
    model_frame(d, p, stop);
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    @(negedge clk);
    while (bus0.busy_out !== 1'b0 && n < 40 * CPB) begin
      @(negedge clk);
      n++;
    end
    n_cmp++;
    if (bus0.busy_out !== 1'b0) begin
      n_bad++;
      $display("FAIL %s idle_timeout: busy_out=%b required 0", tag, bus0.busy_out);
    end
    repeat (2) @(negedge clk);
    @(posedge clk);
    #1;
  endtask

  // ------------------------------------------------------------------
  task automatic test_reset();
    rst_n   = 1'b0;
    rx_line = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({bus0.data_out, bus0.valid_out, bus0.framing_err_out, bus0.parity_err_out, bus0.busy_out} !== 12'h001) begin
      n_bad++;
      $display("FAIL reset_outputs: data=%h v=%b fe=%b pe=%b busy=%b required data=00 v=0 fe=0 pe=0 busy=1",
               bus0.data_out, bus0.valid_out, bus0.framing_err_out, bus0.parity_err_out, bus0.busy_out);
    end
    n_cmp++;
    if (bus0.byte_count_out !== 16'd0 || bus1.byte_count_out !== 2'd0) begin
      n_bad++;
      $display("FAIL reset_count: got %0d/%0d required 0/0", bus0.byte_count_out, bus1.byte_count_out);
    end
    rst_n = 1'b1;
    begin
      int n = 0;
      while (bus0.busy_out !== 1'b0 && n < 3) begin
        @(negedge clk);
        n++;
      end
      n_cmp++;
      if (bus0.busy_out !== 1'b0) begin
        n_bad++;
        $display("FAIL reset_to_idle: busy_out=%b after %0d cycles required 0", bus0.busy_out, n);
      end
    end
    @(posedge clk);
    #1;
    clear_logs();
  endtask

  task automatic test_single();
    send_frame(8'hA5, ^8'hA5, 1'b1, CPB);
    wait_idle("single");
    n_cmp++;
    if (got_q.size() != 1 || got_q[0] !== 8'hA5) begin
      n_bad++;
      $display("FAIL single_valid: got %0d strobes first=%h required 1 strobe of a5",
               got_q.size(), (got_q.size() > 0) ? got_q[0] : 8'hxx);
    end
    n_cmp++;
    if (bus0.data_out !== 8'hA5 || bus0.byte_count_out !== 16'd1) begin
      n_bad++;
      $display("FAIL single_data_count: got data=%h count=%0d required a5/1", bus0.data_out, bus0.byte_count_out);
    end
    n_cmp++;
    if (got_ferr != 0 || got_perr != 0) begin
      n_bad++;
      $display("FAIL single_errors: got fe=%0d pe=%0d required 0/0", got_ferr, got_perr);
    end
    clear_logs();
  endtask

  task automatic test_back_to_back();
    logic [7:0] fixed[3];
    logic [7:0] d;
    fixed[0] = 8'h00; fixed[1] = 8'hFF; fixed[2] = 8'h3C;
    for (int i = 0; i < 3; i++) send_frame(fixed[i], ^fixed[i], 1'b1, CPB);
    for (int i = 0; i < 8; i++) begin
      d = 8'($urandom);
      send_frame(d, ^d, 1'b1, CPB);
      send_bit(1'b1, $urandom_range(0, 3));
    end
    wait_idle("back_to_back");
    n_cmp++;
    if (got_q.size() != exp_q.size()) begin
      n_bad++;
      $display("FAIL b2b_strobe_count: got %0d required %0d", got_q.size(), exp_q.size());
    end else begin
      foreach (exp_q[i]) begin
        n_cmp++;
        if (got_q[i] !== exp_q[i]) begin
          n_bad++;
          $display("FAIL b2b_byte[%0d]: got %h required %h", i, got_q[i], exp_q[i]);
        end
      end
    end
    n_cmp++;
    if (bus0.byte_count_out !== 16'(model_good) || bus0.data_out !== model_data) begin
      n_bad++;
      $display("FAIL b2b_count_data: got %0d/%h required %0d/%h",
               bus0.byte_count_out, bus0.data_out, model_good, model_data);
    end
    clear_logs();
  endtask

  task automatic test_glitch();
    for (int i = 0; i < 4; i++) begin
      send_bit(1'b0, (i == 0) ? 2 : $urandom_range(1, 3));
      send_bit(1'b1, 2 * CPB);
    end
    n_cmp++;
    if (bus0.busy_out !== 1'b0) begin
      n_bad++;
      $display("FAIL glitch_idle: busy_out=%b required 0", bus0.busy_out);
    end
    n_cmp++;
    if (got_q.size() != 0 || got_ferr != 0 || got_perr != 0 || bus0.byte_count_out !== 16'(model_good)) begin
      n_bad++;
      $display("FAIL glitch_no_strobe: got v=%0d fe=%0d pe=%0d count=%0d required 0/0/0/%0d",
               got_q.size(), got_ferr, got_perr, bus0.byte_count_out, model_good);
    end
    clear_logs();
  endtask

  task automatic test_framing();
    send_frame(8'h5A, ^8'h5A, 1'b0, CPB + 40);
    n_cmp++;
    if (bus0.busy_out !== 1'b1) begin
      n_bad++;
      $display("FAIL framing_break_hold: busy_out=%b required 1", bus0.busy_out);
    end
    rx_line = 1'b1;
    wait_idle("framing");
    n_cmp++;
    if (got_ferr != exp_ferr || got_q.size() != 0 || got_perr != 0) begin
      n_bad++;
      $display("FAIL framing_strobes: got fe=%0d v=%0d pe=%0d required fe=%0d v=0 pe=0",
               got_ferr, got_q.size(), got_perr, exp_ferr);
    end
    n_cmp++;
    if (bus0.data_out !== model_data || bus0.byte_count_out !== 16'(model_good)) begin
      n_bad++;
      $display("FAIL framing_data_kept: got %h/%0d required %h/%0d",
               bus0.data_out, bus0.byte_count_out, model_data, model_good);
    end
    clear_logs();
  endtask

  task automatic test_parity();
    send_frame(8'h07, 1'b0, 1'b1, CPB);
    send_frame(8'h07, 1'b1, 1'b1, CPB);
    wait_idle("parity");
    n_cmp++;
    if (got_perr != exp_perr || got_ferr != 0) begin
      n_bad++;
      $display("FAIL parity_err_count: got pe=%0d fe=%0d required pe=%0d fe=0", got_perr, got_ferr, exp_perr);
    end
    n_cmp++;
    if (got_q.size() != exp_q.size() || bus0.data_out !== model_data) begin
      n_bad++;
      $display("FAIL parity_valid: got %0d strobes data=%h required %0d strobes data=%h",
               got_q.size(), bus0.data_out, exp_q.size(), model_data);
    end
    clear_logs();
  endtask

  task automatic test_reset_mid_frame();
    logic [7:0] d;
    d = 8'($urandom);
    send_bit(1'b0, CPB);
    for (int i = 0; i < 3; i++) send_bit(d[i], CPB);
    send_bit(d[3], CPB / 2);
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({bus0.data_out, bus0.valid_out, bus0.framing_err_out, bus0.parity_err_out, bus0.busy_out} !== 12'h001
        || bus0.byte_count_out !== 16'd0 || bus1.byte_count_out !== 2'd0) begin
      n_bad++;
      $display("FAIL midreset_outputs: data=%h v=%b fe=%b pe=%b busy=%b cnt=%0d/%0d required 00/0/0/0/1 cnt 0/0",
               bus0.data_out, bus0.valid_out, bus0.framing_err_out, bus0.parity_err_out,
               bus0.busy_out, bus0.byte_count_out, bus1.byte_count_out);
    end
    rx_line = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_data = 8'h00;
    model_good = 0;
    @(posedge clk);
    #1;
    n_cmp++;
    if (got_q.size() != 0 || got_ferr != 0 || got_perr != 0) begin
      n_bad++;
      $display("FAIL midreset_no_strobe: got v=%0d fe=%0d pe=%0d required 0/0/0", got_q.size(), got_ferr, got_perr);
    end
    clear_logs();
    send_frame(8'h81, ^8'h81, 1'b1, CPB);
    wait_idle("midreset");
    n_cmp++;
    if (got_q.size() != 1 || bus0.data_out !== 8'h81 || bus0.byte_count_out !== 16'd1) begin
      n_bad++;
      $display("FAIL midreset_next_frame: got %0d strobes data=%h count=%0d required 1/81/1",
               got_q.size(), bus0.data_out, bus0.byte_count_out);
    end
    clear_logs();
  endtask

  task automatic test_saturation();
    logic [7:0] d;
    int exp_sat;
    for (int i = 0; i < 5; i++) begin
      d = 8'($urandom);
      send_frame(d, ^d, 1'b1, CPB);
    end
    wait_idle("saturation");
    exp_sat = (model_good > 3) ? 3 : model_good;
    n_cmp++;
    if (bus1.byte_count_out !== 2'(exp_sat)) begin
      n_bad++;
      $display("FAIL sat_count: got %0d required %0d", bus1.byte_count_out, exp_sat);
    end
    n_cmp++;
    if (bus0.byte_count_out !== 16'(model_good) || bus0.data_out !== model_data) begin
      n_bad++;
      $display("FAIL sat_wide_count: got %0d/%h required %0d/%h",
               bus0.byte_count_out, bus0.data_out, model_good, model_data);
    end
    n_cmp++;
    if (excl_viol != 0) begin
      n_bad++;
      $display("FAIL strobe_exclusive: got %0d overlapping cycles required 0", excl_viol);
    end
    clear_logs();
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_glitch();
    test_framing();
    test_parity();
    test_reset_mid_frame();
    test_saturation();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/optical_byte_rx.md
# optical_byte_rx

Receive end of the optical audio link. It recovers the asynchronous serial byte stream that the transmit FPGA sends out of its optical emitter, after those bytes have been read from the SD card. The block synchronizes the photodiode input, detects and validates start bits, samples each bit at mid-period and checks framing. Each recovered byte is presented with a one-cycle valid strobe to the downstream audio path, and a saturating count of received bytes is kept for the LED/seven-segment debug display.

## Interface
Parameters:
- CLKS_PER_BIT, 25: clock cycles per serial bit (25 MHz clock gives 1 Mbit/s); legal range ≥ 4
- COUNT_W, 16: width of the received-byte counter

Ports:
- clk_in  input  1  system clock (25 MHz domain)
- rst_n_in  input  1  asynchronous, active-low reset
- rx_in  input  1  raw optical receiver line; idle high; asynchronous to clk_in
- data_out  output  8  last good received byte
- valid_out  output  1  one-cycle strobe; data_out is new this cycle
- framing_err_out  output  1  one-cycle strobe; stop bit sampled low
- parity_err_out  output  1  one-cycle strobe; parity mismatch (see Configuration)
- byte_count_out  output  COUNT_W  count of good bytes, saturating
- busy_out  output  1  high whenever the FSM is not in IDLE

## Operation
- rx_in passes through a 2-flop synchronizer; the FSM uses only the synchronized line, rx_s.
- Frame format, bits LSB first: start (0), d0..d7, [parity], stop (1).
- FSM states: IDLE, START, DATA, PARITY, STOP, BREAK.
- IDLE: when rx_s = 0, go to START and clear the bit-period counter.
- START: at count CLKS_PER_BIT/2 (floor), resample rx_s.
  - rx_s = 0: go to DATA and restart the counter.
  - rx_s = 1: false start; return to IDLE with no strobe.
- DATA: at each count CLKS_PER_BIT−1, shift rx_s into the MSB of the shift register and restart the counter. After 8 bits, go to PARITY if enabled, otherwise to STOP.
- PARITY: sample one bit the same way, then go to STOP.
- STOP: sample rx_s at CLKS_PER_BIT−1.
  - rx_s = 1 and parity ok: load data_out, pulse valid_out, increment byte_count_out, go to IDLE.
  - rx_s = 1 and parity bad: pulse parity_err_out only; data_out is unchanged; go to IDLE.
  - rx_s = 0: pulse framing_err_out only; go to BREAK. Framing error takes priority over parity error.
- BREAK: wait until rx_s = 1, then go to IDLE. This prevents a stuck-low line from producing repeated frames.
- byte_count_out saturates at 2^COUNT_W−1 and never wraps.
- Strobes are mutually exclusive: at most one of valid_out, framing_err_out and parity_err_out is high in any cycle.

## Timing
- Reset values, applied asynchronously:
  - state = BREAK
  - data_out = 0x00, byte_count_out = 0
  - all strobes = 0, busy_out = 1
  - both synchronizer flops = 1
- After reset releases with the line idle, the FSM reaches IDLE within 3 cycles.
- rx_in to rx_s latency is 2 cycles.
- The start edge is validated CLKS_PER_BIT/2 cycles after rx_s falls. Every later sample lands one bit period after the previous one.
- Strobes register in the cycle after the stop-bit sample and are high for exactly 1 cycle. data_out and byte_count_out update in that same cycle.
- Back-to-back frames are supported. A new start bit can be detected in the first cycle after STOP returns to IDLE, so a stop bit as short as CLKS_PER_BIT/2+1 cycles is tolerated.
- Reset asserted mid-frame aborts the frame immediately and produces no strobe.

## Configuration
- OPTICAL_RX_PARITY_EN defined:
  - The frame carries an even-parity bit after d7; the PARITY state is used.
  - The check is: XOR of the 8 data bits and the parity bit must equal 0.
- Not defined:
  - There is no parity bit; DATA goes directly to STOP.
  - parity_err_out is tied to 0 and the PARITY state logic is compiled out.

## Structure
- Package optical_pkg holds:
  - the state enum (IDLE, START, DATA, PARITY, STOP, BREAK)
  - DEFAULT_CLKS_PER_BIT = 25
  - IDLE_LEVEL = 1'b1
- The transmitter on the other FPGA shares this package.
- Sub-module sync_2ff: a 1-bit, two-flop synchronizer with an asynchronous active-low preset to 1.

## Test plan
Bench uses CLKS_PER_BIT = 8.
- Frame 0xA5 with a valid stop bit -> data_out = 0xA5, valid_out high for 1 cycle, byte_count_out = 1, no error strobes.
- Back-to-back frames 0x00, 0xFF, 0x3C with minimal idle -> three valid strobes with those values in order; byte_count_out = 3.
- Low glitch of 2 cycles on an idle line -> FSM returns to IDLE; no strobe; byte_count_out unchanged.
- Frame 0x5A with the stop bit held low, line low for 40 more cycles -> one framing_err_out pulse; state stays BREAK until the line goes high; data_out keeps its prior value.
- Reset pulsed in the middle of d3 of a frame -> all outputs return to their reset values with no strobe; the next clean frame 0x81 is received correctly.
- With OPTICAL_RX_PARITY_EN, 0x07 sent with wrong parity bit 0 -> parity_err_out pulses and there is no valid_out. Separately, with COUNT_W = 2, 5 good frames -> byte_count_out = 3 (saturated).
